// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register bank: address map, lock keys,
// lock state encoding and reset values.
package pwm_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_UPD_FORCE = 8'h01;
  localparam logic [7:0] ADDR_STATUS    = 8'h02;
  localparam logic [7:0] ADDR_LOCK      = 8'h03;
  localparam logic [7:0] CORE_BASE      = 8'h10;
  localparam logic [7:0] CH_BASE        = 8'h40;
  localparam logic [7:0] ADDR_SOFT_RST  = 8'hFF;

  // Window of addresses that the write lock protects (besides CTRL/UPD_FORCE)
  localparam logic [7:0] PROT_LO = 8'h10;
  localparam logic [7:0] PROT_HI = 8'h7F;

  localparam logic [7:0] KEY_A = 8'h5A;
  localparam logic [7:0] KEY_B = 8'hA5;

  localparam logic [7:0] DTG_RST = 8'h01;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_KEY1     = 2'd1,
    LK_LOCKED   = 2'd2,
    LK_UKEY1    = 2'd3
  } lock_state_e;

  function automatic int core_of_ch(input int ch, input int ch_per_core);
    return ch / ch_per_core;
  endfunction

endpackage

// File: rtl/pwm_regbank_if.sv
// Register-bus interface between the I2C slave and the PWM register bank.
interface pwm_regbank_if #(
  parameter int WIDTH = 16
);
  logic             wr_en_i;
  logic             rd_en_i;
  logic [7:0]       addr_i;
  logic [WIDTH-1:0] wr_data_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             err_o;

  modport master (
    output wr_en_i, rd_en_i, addr_i, wr_data_i,
    input  rd_data_o, rd_valid_o, err_o
  );

  modport slave (
    input  wr_en_i, rd_en_i, addr_i, wr_data_i,
    output rd_data_o, rd_valid_o, err_o
  );
endinterface

// File: rtl/pwm_regbank_lock.sv
// Two-key write-lock sequencer. Locking needs 0x5A then 0xA5 on LOCK,
// unlocking needs 0xA5 then 0x5A; an intervening write aborts the sequence.
module pwm_regbank_lock
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [7:0]       addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             locked_o
);

  lock_state_e state_reg, state_next;
  logic key_wr, is_key_a, is_key_b;

  assign key_wr   = wr_en_i && (addr_i == ADDR_LOCK);
  assign is_key_a = (wr_data_i == WIDTH'(KEY_A));
  assign is_key_b = (wr_data_i == WIDTH'(KEY_B));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= LK_UNLOCKED;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      LK_UNLOCKED: if (key_wr && is_key_a) state_next = LK_KEY1;
      LK_KEY1: begin
        if (key_wr && is_key_b) state_next = LK_LOCKED;
        else if (wr_en_i)       state_next = LK_UNLOCKED;
      end
      LK_LOCKED:   if (key_wr && is_key_b) state_next = LK_UKEY1;
      LK_UKEY1: begin
        if (key_wr && is_key_a) state_next = LK_UNLOCKED;
        else if (wr_en_i)       state_next = LK_LOCKED;
      end
      default:     state_next = LK_UNLOCKED;
    endcase
  end

  assign locked_o = (state_reg == LK_LOCKED) || (state_reg == LK_UKEY1);

endmodule

// File: rtl/pwm_regbank.sv
// PWM register bank: preload registers per core/channel, committed to the
// active outputs on each core's update event, with write lock and read path.
module pwm_regbank
  import pwm_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_CORES   = 4,
  parameter int CH_PER_CORE = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  pwm_regbank_if.slave                           bus,
  input  logic [NUM_CORES-1:0]                   upd_evt_i,
  output logic                                   sys_soft_rst_n_o,
  output logic [NUM_CORES-1:0]                   cen_o,
  output logic [NUM_CORES*WIDTH-1:0]             psc_o,
  output logic [NUM_CORES*WIDTH-1:0]             arr_o,
  output logic [NUM_CORES*CH_PER_CORE*WIDTH-1:0] cmp_start_o,
  output logic [NUM_CORES*CH_PER_CORE*WIDTH-1:0] cmp_end_o,
  output logic [NUM_CORES*CH_PER_CORE*WIDTH-1:0] cfg_o,
  output logic [NUM_CORES*CH_PER_CORE*8-1:0]     dtg_o
);

  localparam int NUM_CH   = NUM_CORES * CH_PER_CORE;
  localparam int LOCK_BIT = (WIDTH > 15) ? 15 : WIDTH - 1;
  localparam logic [7:0] CORE_END = CORE_BASE + 8'(2 * NUM_CORES);
  localparam logic [7:0] CH_END   = CH_BASE + 8'(4 * NUM_CH);

  logic             locked;
  logic [7:0]       core_off, ch_off;
  logic             core_hit, ch_hit, prot_hit, wr_mapped, rd_mapped, wr_ok;
  logic [NUM_CORES-1:0] cen_reg, pending, pend_set, force_vec, commit;
  logic [NUM_CH-1:0]    ch_set;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg, err_reg, srst_n_reg;

  logic [WIDTH-1:0] psc_pre [NUM_CORES];
  logic [WIDTH-1:0] arr_pre [NUM_CORES];
  logic [WIDTH-1:0] cs_pre  [NUM_CH];
  logic [WIDTH-1:0] ce_pre  [NUM_CH];
  logic [WIDTH-1:0] cfg_pre [NUM_CH];
  logic [7:0]       dtg_pre [NUM_CH];

  pwm_regbank_lock #(.WIDTH(WIDTH)) u_lock (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (bus.wr_en_i),
    .addr_i    (bus.addr_i),
    .wr_data_i (bus.wr_data_i),
    .locked_o  (locked)
  );

  assign core_off  = bus.addr_i - CORE_BASE;
  assign ch_off    = bus.addr_i - CH_BASE;
  assign core_hit  = (bus.addr_i >= CORE_BASE) && (bus.addr_i < CORE_END);
  assign ch_hit    = (bus.addr_i >= CH_BASE) && (bus.addr_i < CH_END);
  assign prot_hit  = (bus.addr_i == ADDR_CTRL) || (bus.addr_i == ADDR_UPD_FORCE) ||
                     ((bus.addr_i >= PROT_LO) && (bus.addr_i <= PROT_HI));
  assign wr_mapped = (bus.addr_i == ADDR_CTRL) || (bus.addr_i == ADDR_UPD_FORCE) ||
                     (bus.addr_i == ADDR_LOCK) || (bus.addr_i == ADDR_SOFT_RST) ||
                     core_hit || ch_hit;
  // Write-only registers read back as zero without flagging an error
  assign rd_mapped = wr_mapped || (bus.addr_i == ADDR_STATUS);
  assign wr_ok     = bus.wr_en_i && wr_mapped && !(locked && prot_hit);

  assign force_vec = (wr_ok && bus.addr_i == ADDR_UPD_FORCE) ? bus.wr_data_i[NUM_CORES-1:0] : '0;
  // A stopped core has no update events, so its preload goes live right away
  assign commit    = pending & (upd_evt_i | force_vec | ~cen_reg);

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic             sel;
    logic             pending_reg;
    logic [WIDTH-1:0] psc_pre_reg, arr_pre_reg, psc_act_reg, arr_act_reg;

    assign sel          = wr_ok && core_hit && (core_off[7:1] == 7'(gi));
    assign pend_set[gi] = sel || (|ch_set[gi*CH_PER_CORE +: CH_PER_CORE]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        psc_pre_reg <= '0;
        arr_pre_reg <= '1;
        psc_act_reg <= '0;
        arr_act_reg <= '1;
        pending_reg <= 1'b0;
      end else begin
        if (commit[gi]) begin
          psc_act_reg <= psc_pre_reg;
          arr_act_reg <= arr_pre_reg;
        end
        if (sel && !bus.addr_i[0]) psc_pre_reg <= bus.wr_data_i;
        if (sel && bus.addr_i[0])  arr_pre_reg <= bus.wr_data_i;
        // A fresh write in the commit cycle keeps the core pending
        pending_reg <= pend_set[gi] || (pending_reg && !commit[gi]);
      end
    end

    assign pending[gi]               = pending_reg;
    assign psc_pre[gi]               = psc_pre_reg;
    assign arr_pre[gi]               = arr_pre_reg;
    assign psc_o[gi*WIDTH +: WIDTH]  = psc_act_reg;
    assign arr_o[gi*WIDTH +: WIDTH]  = arr_act_reg;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam int OWNER = core_of_ch(gi, CH_PER_CORE);
    logic             sel;
    logic [WIDTH-1:0] cs_pre_reg, ce_pre_reg, cfg_pre_reg;
    logic [WIDTH-1:0] cs_act_reg, ce_act_reg, cfg_act_reg;
    logic [7:0]       dtg_pre_reg, dtg_act_reg;

    assign sel        = wr_ok && ch_hit && (ch_off[7:2] == 6'(gi));
    assign ch_set[gi] = sel;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cs_pre_reg  <= '0;
        ce_pre_reg  <= '0;
        cfg_pre_reg <= '0;
        dtg_pre_reg <= DTG_RST;
        cs_act_reg  <= '0;
        ce_act_reg  <= '0;
        cfg_act_reg <= '0;
        dtg_act_reg <= DTG_RST;
      end else begin
        if (commit[OWNER]) begin
          cs_act_reg  <= cs_pre_reg;
          ce_act_reg  <= ce_pre_reg;
          cfg_act_reg <= cfg_pre_reg;
          dtg_act_reg <= dtg_pre_reg;
        end
        if (sel) begin
          unique case (bus.addr_i[1:0])
            2'd0:    cs_pre_reg  <= bus.wr_data_i;
            2'd1:    ce_pre_reg  <= bus.wr_data_i;
            2'd2:    dtg_pre_reg <= bus.wr_data_i[7:0];
            default: cfg_pre_reg <= bus.wr_data_i;
          endcase
        end
      end
    end

    assign cs_pre[gi]                     = cs_pre_reg;
    assign ce_pre[gi]                     = ce_pre_reg;
    assign cfg_pre[gi]                    = cfg_pre_reg;
    assign dtg_pre[gi]                    = dtg_pre_reg;
    assign cmp_start_o[gi*WIDTH +: WIDTH] = cs_act_reg;
    assign cmp_end_o[gi*WIDTH +: WIDTH]   = ce_act_reg;
    assign cfg_o[gi*WIDTH +: WIDTH]       = cfg_act_reg;
    assign dtg_o[gi*8 +: 8]               = dtg_act_reg;
  end

  always_comb begin
    rd_val = '0;
    if (bus.addr_i == ADDR_CTRL) begin
      rd_val[NUM_CORES-1:0] = cen_reg;
    end else if (bus.addr_i == ADDR_STATUS) begin
      rd_val[NUM_CORES-1:0] = pending;
      rd_val[LOCK_BIT]      = locked;
    end else if (core_hit) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (core_off[7:1] == 7'(c)) rd_val = bus.addr_i[0] ? arr_pre[c] : psc_pre[c];
      end
    end else if (ch_hit) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_off[7:2] == 6'(n)) begin
          unique case (bus.addr_i[1:0])
            2'd0:    rd_val = cs_pre[n];
            2'd1:    rd_val = ce_pre[n];
            2'd2:    rd_val = WIDTH'(dtg_pre[n]);
            default: rd_val = cfg_pre[n];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      srst_n_reg   <= 1'b1;
      cen_reg      <= '0;
    end else begin
      rd_valid_reg <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_reg <= rd_val;
      err_reg      <= (bus.rd_en_i && !rd_mapped) || (bus.wr_en_i && !wr_ok);
      srst_n_reg   <= !(wr_ok && (bus.addr_i == ADDR_SOFT_RST) && bus.wr_data_i[0]);
      if (wr_ok && (bus.addr_i == ADDR_CTRL)) cen_reg <= bus.wr_data_i[NUM_CORES-1:0];
    end
  end

  assign bus.rd_data_o    = rd_data_reg;
  assign bus.rd_valid_o   = rd_valid_reg;
  assign bus.err_o        = err_reg;
  assign sys_soft_rst_n_o = srst_n_reg;
  assign cen_o            = cen_reg;

endmodule

// File: tb/tb_pwm_regbank.sv
// Bench for pwm_regbank: directed vector table, hand-written corner sequences
// and random traffic, all checked against a register-map reference model.
module tb_pwm_regbank;
  localparam int W = 16, NC = 4, CPC = 2, NCH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] upd_evt = '0;
  logic srst_n;
  logic [NC-1:0] cen;
  logic [NC*W-1:0] psc, arr;
  logic [NCH*W-1:0] cs, ce, cfg;
  logic [NCH*8-1:0] dtg;

  pwm_regbank_if #(.WIDTH(W)) bus_if();

  pwm_regbank #(.WIDTH(W), .NUM_CORES(NC), .CH_PER_CORE(CPC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_if.slave), .upd_evt_i(upd_evt),
    .sys_soft_rst_n_o(srst_n), .cen_o(cen), .psc_o(psc), .arr_o(arr),
    .cmp_start_o(cs), .cmp_end_o(ce), .cfg_o(cfg), .dtg_o(dtg)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, ntxn = 0;

  // Reference model state (slot 0 cmp_start, 1 cmp_end, 2 dtg, 3 cfg)
  bit [3:0]  m_cen, m_pend;
  bit [15:0] m_psc_p [NC], m_arr_p [NC], m_psc_a [NC], m_arr_a [NC];
  bit [15:0] m_ch_p [NCH][4], m_ch_a [NCH][4];
  bit        m_locked, m_armed, m_rd_valid, m_err, m_srst;
  bit [15:0] m_rd_data;

  typedef struct {
    logic wr; logic rd; logic [7:0] a; logic [15:0] d; logic [3:0] evt;
    logic ev; logic [15:0] er; logic ee; logic [15:0] earr0;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] a,
                              input logic [15:0] d, input logic [3:0] evt, input logic ev,
                              input logic [15:0] er, input logic ee, input logic [15:0] earr0);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.evt = evt;
    v.ev = ev; v.er = er; v.ee = ee; v.earr0 = earr0;
    return v;
  endfunction

  function automatic bit is_core(input logic [7:0] a);
    return (a >= 8'h10) && (a < 8'h18);
  endfunction

  function automatic bit is_ch(input logic [7:0] a);
    return (a >= 8'h40) && (a < 8'h60);
  endfunction

  function automatic bit [15:0] read_model(input logic [7:0] a);
    bit [15:0] v;
    int idx;
    v = 16'h0;
    if (a == 8'h00) v = {12'h0, m_cen};
    else if (a == 8'h02) v = {m_locked, 11'h0, m_pend};
    else if (is_core(a)) begin
      idx = (int'(a) - 16) / 2;
      v = a[0] ? m_arr_p[idx] : m_psc_p[idx];
    end else if (is_ch(a)) begin
      idx = int'(a) - 64;
      v = m_ch_p[idx / 4][idx % 4];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_cen = '0; m_pend = '0;
    for (int c = 0; c < NC; c++) begin
      m_psc_p[c] = 16'h0; m_psc_a[c] = 16'h0; m_arr_p[c] = 16'hFFFF; m_arr_a[c] = 16'hFFFF;
    end
    for (int n = 0; n < NCH; n++) begin
      for (int k = 0; k < 4; k++) begin
        m_ch_p[n][k] = (k == 2) ? 16'h1 : 16'h0;
        m_ch_a[n][k] = m_ch_p[n][k];
      end
    end
    m_locked = 0; m_armed = 0; m_rd_valid = 0; m_err = 0; m_srst = 1; m_rd_data = 16'h0;
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [7:0] a,
                            input logic [15:0] d, input logic [3:0] evt);
    bit prot, mapped_w, mapped_r, acc;
    bit [3:0] fv, commit, setp;
    int idx;
    prot     = (a == 8'h00) || (a == 8'h01) || ((a >= 8'h10) && (a <= 8'h7F));
    mapped_w = (a == 8'h00) || (a == 8'h01) || (a == 8'h03) || (a == 8'hFF) || is_core(a) || is_ch(a);
    mapped_r = mapped_w || (a == 8'h02);
    acc      = wr && mapped_w && !(m_locked && prot);
    m_rd_valid = rd;
    if (rd) m_rd_data = read_model(a);
    m_err  = (rd && !mapped_r) || (wr && !acc);
    m_srst = !(acc && (a == 8'hFF) && d[0]);
    fv = (acc && a == 8'h01) ? d[3:0] : 4'h0;
    for (int c = 0; c < NC; c++) begin
      commit[c] = m_pend[c] && (evt[c] || fv[c] || !m_cen[c]);
      if (commit[c]) begin
        m_psc_a[c] = m_psc_p[c];
        m_arr_a[c] = m_arr_p[c];
        for (int n = c * CPC; n < (c + 1) * CPC; n++)
          for (int k = 0; k < 4; k++) m_ch_a[n][k] = m_ch_p[n][k];
      end
    end
    setp = '0;
    if (acc) begin
      if (a == 8'h00) m_cen = d[3:0];
      if (is_core(a)) begin
        idx = (int'(a) - 16) / 2;
        if (a[0]) m_arr_p[idx] = d; else m_psc_p[idx] = d;
        setp[idx] = 1'b1;
      end
      if (is_ch(a)) begin
        idx = int'(a) - 64;
        m_ch_p[idx / 4][idx % 4] = ((idx % 4) == 2) ? (d & 16'h00FF) : d;
        setp[(idx / 4) / CPC] = 1'b1;
      end
    end
    m_pend = (m_pend & ~commit) | setp;
    if (wr && a == 8'h03) begin
      if (!m_locked && !m_armed)     m_armed = (d == 16'h005A);
      else if (!m_locked && m_armed) begin m_locked = (d == 16'h00A5); m_armed = 0; end
      else if (m_locked && !m_armed) m_armed = (d == 16'h00A5);
      else begin m_locked = !(d == 16'h005A); m_armed = 0; end
    end else if (wr) begin
      m_armed = 0;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_all();
    logic [NC*W-1:0] e_psc, e_arr;
    logic [NCH*W-1:0] e_cs, e_ce, e_cfg;
    logic [NCH*8-1:0] e_dtg;
    for (int c = 0; c < NC; c++) begin
      e_psc[c*W +: W] = m_psc_a[c];
      e_arr[c*W +: W] = m_arr_a[c];
    end
    for (int n = 0; n < NCH; n++) begin
      e_cs[n*W +: W]  = m_ch_a[n][0];
      e_ce[n*W +: W]  = m_ch_a[n][1];
      e_dtg[n*8 +: 8] = m_ch_a[n][2][7:0];
      e_cfg[n*W +: W] = m_ch_a[n][3];
    end
    chk("rd_valid", bus_if.rd_valid_o, m_rd_valid);
    chk("rd_data", bus_if.rd_data_o, m_rd_data);
    chk("err", bus_if.err_o, m_err);
    chk("soft_rst_n", srst_n, m_srst);
    chk("cen", cen, m_cen);
    chk("psc", psc, e_psc);
    chk("arr", arr, e_arr);
    chk("cmp_start", cs, e_cs);
    chk("cmp_end", ce, e_ce);
    chk("dtg", dtg, e_dtg);
    chk("cfg", cfg, e_cfg);
  endtask

  task automatic apply(input logic wr, input logic rd, input logic [7:0] a,
                       input logic [15:0] d, input logic [3:0] evt);
    bus_if.wr_en_i = wr; bus_if.rd_en_i = rd; bus_if.addr_i = a; bus_if.wr_data_i = d;
    upd_evt = evt;
    @(posedge clk);
    #1;
    bus_if.wr_en_i = 1'b0; bus_if.rd_en_i = 1'b0; upd_evt = '0;
    model_step(wr, rd, a, d, evt);
    ntxn++;
    $display("txn %0d wr=%0b rd=%0b addr=%02h data=%04h evt=%h -> rd_valid=%0b rd_data=%04h err=%0b",
             ntxn, wr, rd, a, d, evt, bus_if.rd_valid_o, bus_if.rd_data_o, bus_if.err_o);
    check_all();
  endtask

  initial begin
    logic [7:0] a;
    logic [15:0] d;
    int r;
    bus_if.wr_en_i = 1'b0; bus_if.rd_en_i = 1'b0; bus_if.addr_i = '0; bus_if.wr_data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();

    // wr rd addr data evt | rd_valid rd_data err arr_o[core0]
    tbl.push_back(mk(0,1,8'h11,16'h0000,4'h0, 1,16'hFFFF,0,16'hFFFF));
    tbl.push_back(mk(0,1,8'h42,16'h0000,4'h0, 1,16'h0001,0,16'hFFFF));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h0000,0,16'hFFFF));
    tbl.push_back(mk(0,1,8'h30,16'h0000,4'h0, 1,16'h0000,1,16'hFFFF));
    tbl.push_back(mk(1,0,8'h00,16'h0001,4'h0, 0,16'h0000,0,16'hFFFF));
    tbl.push_back(mk(1,0,8'h11,16'h0100,4'h0, 0,16'h0000,0,16'hFFFF));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h0001,0,16'hFFFF));
    tbl.push_back(mk(0,0,8'h00,16'h0000,4'h1, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,1,8'h11,16'h0000,4'h0, 1,16'h0100,0,16'h0100));
    tbl.push_back(mk(1,0,8'h03,16'h005A,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h03,16'h00A5,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h8000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h10,16'h0005,4'h0, 0,16'h0000,1,16'h0100));
    tbl.push_back(mk(0,1,8'h10,16'h0000,4'h0, 1,16'h0000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h00,16'h000F,4'h0, 0,16'h0000,1,16'h0100));
    tbl.push_back(mk(1,0,8'h03,16'h00A5,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h03,16'h005A,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h0000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h10,16'h0005,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,1,8'h10,16'h0000,4'h0, 1,16'h0005,0,16'h0100));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h0001,0,16'h0100));
    tbl.push_back(mk(1,0,8'h03,16'h005A,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h11,16'h0200,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(1,0,8'h03,16'h00A5,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,1,8'h02,16'h0000,4'h0, 1,16'h0001,0,16'h0100));
    tbl.push_back(mk(1,0,8'h10,16'h0006,4'h0, 0,16'h0000,0,16'h0100));
    tbl.push_back(mk(0,0,8'h00,16'h0000,4'h1, 0,16'h0000,0,16'h0200));
    tbl.push_back(mk(1,1,8'h11,16'h0300,4'h0, 1,16'h0200,0,16'h0200));
    tbl.push_back(mk(1,0,8'h02,16'h0001,4'h0, 0,16'h0000,1,16'h0200));
    tbl.push_back(mk(1,0,8'h80,16'h0001,4'h0, 0,16'h0000,1,16'h0200));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].evt);
      chk("tbl_rd_valid", bus_if.rd_valid_o, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_rd_data", bus_if.rd_data_o, tbl[i].er);
      chk("tbl_err", bus_if.err_o, tbl[i].ee);
      chk("tbl_arr0", arr[15:0], tbl[i].earr0);
    end

    // Stopped core 1: CMP_START_3 goes live one cycle after the preload
    apply(1, 0, 8'h4C, 16'h0040, 4'h0);
    chk("cs3_not_yet", cs[3*W +: W], 16'h0000);
    apply(0, 0, 8'h00, 16'h0000, 4'h0);
    chk("cs3_live", cs[3*W +: W], 16'h0040);

    // Write racing an update event on the same core
    apply(1, 0, 8'h00, 16'h0003, 4'h0);
    apply(1, 0, 8'h13, 16'h0AAA, 4'h0);
    chk("arr1_held", arr[1*W +: W], 16'hFFFF);
    apply(1, 0, 8'h13, 16'h1234, 4'h2);
    chk("arr1_old_preload", arr[1*W +: W], 16'h0AAA);
    apply(0, 1, 8'h02, 16'h0000, 4'h0);
    chk("status_pend1", bus_if.rd_data_o, 16'h0003);
    apply(1, 0, 8'h01, 16'h0002, 4'h0);
    chk("arr1_forced", arr[1*W +: W], 16'h1234);
    apply(0, 1, 8'h02, 16'h0000, 4'h0);
    chk("status_after_force", bus_if.rd_data_o, 16'h0001);

    // Soft reset pulse
    apply(1, 0, 8'hFF, 16'h0001, 4'h0);
    chk("srst_low", srst_n, 1'b0);
    apply(0, 0, 8'h00, 16'h0000, 4'h0);
    chk("srst_high", srst_n, 1'b1);
    apply(0, 1, 8'h13, 16'h0000, 4'h0);
    chk("arr1_retained", bus_if.rd_data_o, 16'h1234);
    apply(1, 0, 8'hFF, 16'h0000, 4'h0);
    chk("srst_data0", srst_n, 1'b1);

    // Async reset in the middle of a lock key sequence
    apply(1, 0, 8'h03, 16'h005A, 4'h0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_arr", arr, {NC{16'hFFFF}});
    chk("areset_cen", cen, 4'h0);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(1, 0, 8'h03, 16'h00A5, 4'h0);
    apply(0, 1, 8'h02, 16'h0000, 4'h0);
    chk("areset_unlocked", bus_if.rd_data_o, 16'h0000);
    apply(1, 0, 8'h10, 16'h0007, 4'h0);
    chk("areset_wr_ok", bus_if.err_o, 1'b0);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: a = 8'h00;
        1: a = 8'h01;
        2: a = 8'h02;
        3: a = 8'h03;
        4, 5: a = 8'(8'h10 + $urandom_range(0, 7));
        6, 7: a = 8'(8'h40 + $urandom_range(0, 31));
        8: a = 8'hFF;
        default: a = 8'($urandom_range(0, 255));
      endcase
      d = 16'($urandom);
      if (a == 8'h03) begin
        r = int'($urandom_range(0, 2));
        d = (r == 0) ? 16'h005A : ((r == 1) ? 16'h00A5 : d);
      end
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_regbank.md
# pwm_regbank

Parametrised PWM register bank sitting between the I2C slave bus interface and the PWM cores. It stores per-core prescaler/reload and per-channel compare/dead-time/config values in preload registers and commits them to active outputs only on each core's update event, so no PWM period sees a torn configuration. It adds a key-protected write lock, per-core pending status and a registered read path.

## Interface
- WIDTH, 16: data width of bus and timer registers (8..32).
- NUM_CORES, 4: number of PWM cores (1..8).
- CH_PER_CORE, 2: channels per core (1..2); NUM_CH = NUM_CORES*CH_PER_CORE.
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  single-cycle write strobe.
- rd_en_i  in  1  single-cycle read strobe.
- addr_i  in  8  register address.
- wr_data_i  in  WIDTH  write data.
- rd_data_o  out  WIDTH  read data, registered.
- rd_valid_o  out  1  rd_data_o valid, one cycle.
- err_o  out  1  one-cycle pulse on rejected or unmapped access.
- upd_evt_i  in  NUM_CORES  per-core counter-wrap pulse from each core.
- sys_soft_rst_n_o  out  1  one-cycle active-low soft reset pulse.
- cen_o  out  NUM_CORES  counter enables.
- psc_o, arr_o  out  NUM_CORES*WIDTH  active prescaler/reload, core c at slice c.
- cmp_start_o, cmp_end_o, cfg_o  out  NUM_CH*WIDTH  active channel values.
- dtg_o  out  NUM_CH*8  active dead-time values.

## Operation
- Map: 0x00 CTRL (cen, direct, not shadowed); 0x01 UPD_FORCE (W: bit c forces commit of core c); 0x02 STATUS (RO: pending[NUM_CORES-1:0], bit 15 locked); 0x03 LOCK (W key); 0x10+2c PSC_c, 0x11+2c ARR_c; 0x40+4n CMP_START_n, +1 CMP_END_n, +2 DTG_n (data[7:0]), +3 CFG_n; 0xFF SOFT_RST.
- Writes to PSC/ARR/channel addresses land in preload registers and set pending[c] for owning core c = n / CH_PER_CORE.
- Commit core c (all preload → active for core c and its channels, pending[c] cleared) when pending[c] and (upd_evt_i[c] or UPD_FORCE bit c or cen_o[c]==0).
- Reads return preload values (CTRL/STATUS return live state); unmapped read returns 0 and pulses err_o.
- Lock FSM: UNLOCKED → (LOCK write 0x5A) KEY1 → (LOCK write 0xA5) LOCKED; any other write while in KEY1 returns to UNLOCKED and is still processed normally. LOCKED → UNLOCKED by LOCK write 0xA5 then 0x5A (via state UKEY1; wrong data returns to LOCKED). Reset state UNLOCKED.
- While LOCKED or UKEY1, writes to 0x00, 0x01, 0x10–0x7F are dropped and pulse err_o; LOCK and SOFT_RST are always accepted.
- SOFT_RST write with data[0]=1 drives sys_soft_rst_n_o low for exactly one cycle; the bank itself is not cleared by it.
- Reset values: cen 0, psc 0, arr all ones, cmp/cfg 0, dtg 1 (preload and active), pending 0, rd_data_o 0, rd_valid_o 0, err_o 0, sys_soft_rst_n_o 1.

## Timing
- Write visible in preload and pending next edge; active output changes on the edge after the commit condition is sampled.
- Read: rd_data_o/rd_valid_o one cycle after rd_en_i; rd_data_o holds until next read.
- Write and upd_evt_i same cycle for same core: active captures old preload, new value lands in preload, pending stays 1 (set wins).
- Write with cen_o[c]==0: active follows one cycle after preload.
- Simultaneous rd_en_i and wr_en_i to same address: read returns pre-write value.
- Async reset mid-operation clears everything immediately, including in-progress key sequence.

## Structure
- Shared package pwm_pkg: address constants (ADDR_CTRL, ADDR_UPD_FORCE, ADDR_STATUS, ADDR_LOCK, CORE_BASE, CH_BASE, ADDR_SOFT_RST), key constants 0x5A/0xA5, lock state encoding, reset defaults.
- One sub-module pwm_regbank_lock: lock FSM, outputs locked flag.
- Core/channel storage via generate loops indexed by core and channel.

## Test plan
- Reset, read 0x11 → 0xFFFF, 0x42 → 0x0001, STATUS → 0; all active outputs at reset values.
- cen=1, write ARR_0=0x0100 → arr_o[0] unchanged, STATUS=0x0001; pulse upd_evt_i[0] → arr_o[0]=0x0100 next cycle, STATUS=0.
- Write CMP_START_3=0x0040 (core 1) with cen[1]=0 → cmp_start_o slice 3 = 0x0040 two cycles after the write, no event needed.
- LOCK 0x5A, 0xA5; write PSC_0=5 → err_o pulse, PSC_0 reads 0; LOCK 0xA5, 0x5A; write PSC_0=5 accepted.
- Write ARR_1 in same cycle as upd_evt_i[1] → active keeps old value, pending[1]=1; UPD_FORCE=0x2 → new value committed.
- Write 0xFF data 1 → sys_soft_rst_n_o low exactly one cycle, registers retain values.
